// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite responder backed by a word-organised on-chip RAM, with a fixed
// number of wait states per OKAY transfer and two-cycle ERROR responses.
module ahb3lite_sram_slave #(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int ADDR_X = HADDR_SIZE + 1;
  localparam logic [ADDR_X-1:0] MEM_BYTES = ADDR_X'(4 * MEM_DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t                r_state;
  logic [3:0]            r_wait_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [1:0]            r_addr_lo;
  logic [2:0]            r_size;
  logic                  r_write;
  logic                  r_hreadyout;
  logic                  r_hresp;
  logic [HDATA_SIZE-1:0] r_mem [MEM_DEPTH];

  logic       w_can_accept;
  logic       w_accept;
  logic       w_illegal;
  logic       w_mem_we;
  logic [3:0] w_lane_en;
  logic       w_unused;

  // A new address phase is only taken while the previous data phase is finishing.
  assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_ERR2);
  assign w_accept     = HSEL && HREADY && HTRANS[1] && w_can_accept;

  assign w_illegal = (HSIZE > 3'd2)
                  || ((HSIZE == 3'd1) && HADDR[0])
                  || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))
                  || ({1'b0, HADDR} >= MEM_BYTES);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= 4'd0;
      r_idx       <= '0;
      r_addr_lo   <= 2'b00;
      r_size      <= 3'd0;
      r_write     <= 1'b0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (r_wait_cnt == 4'd0) begin
            r_state     <= ST_DATA;
            r_hreadyout <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          r_state     <= ST_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
        end
        default: begin
          if (w_accept) begin
            r_idx     <= HADDR[IDX_W+1:2];
            r_addr_lo <= HADDR[1:0];
            r_size    <= HSIZE;
            r_write   <= HWRITE;
            if (w_illegal) begin
              r_state     <= ST_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              r_state     <= ST_WAIT;
              r_wait_cnt  <= WAIT_LOAD;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b0;
            end else begin
              r_state     <= ST_DATA;
              r_hreadyout <= 1'b1;
              r_hresp     <= 1'b0;
            end
          end else begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
          end
        end
      endcase
    end
  end

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the case can infer a latch.
  always_comb begin
    w_lane_en = 4'b0000;
    case (r_size)
      3'd0:    w_lane_en[r_addr_lo] = 1'b1;
      3'd1:    w_lane_en = r_addr_lo[1] ? 4'b1100 : 4'b0011;
      3'd2:    w_lane_en = 4'b1111;
      default: w_lane_en = 4'b0000;
    endcase
  end

  // Errored transfers never reach DATA, so they cannot touch the array.
  assign w_mem_we = (r_state == ST_DATA) && r_write && HRESETn;

  // NOTE: the storage array has no reset; contents survive HRESETn and a
  // reset branch would prevent mapping onto RAM macros.
  always_ff @(posedge HCLK) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_lane_en[i]) begin
          r_mem[r_idx][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  assign HRDATA    = (r_state == ST_DATA) ? r_mem[r_idx] : '0;
  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;

  // Burst type, protection and the SEQ/NONSEQ distinction do not affect behaviour.
  assign w_unused = ^{HBURST, HPROT, HTRANS[0]};

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Directed bench for ahb3lite_sram_slave: a pipelined master drives transfers
// into a zero-wait and a two-wait instance and scores each data phase.
module tb_ahb3lite_sram_slave;

  logic        HCLK;
  logic        HRESETn;
  logic        hsel0, hsel2;
  logic [31:0] haddr, hwdata;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [31:0] hrdata0, hrdata2;
  logic        hreadyout0, hreadyout2;
  logic        hresp0, hresp2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    bit          err;
    bit          chk;
    logic [31:0] rdata;
    int          waits;
  } req_t;

  typedef struct {
    string       tag;
    bit          err;
    bit          chk;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  req_t q_req[$];
  exp_t q_exp[$];

  ahb3lite_sram_slave #(.WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(hrdata0), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HREADY(hreadyout0), .HREADYOUT(hreadyout0), .HRESP(hresp0)
  );

  ahb3lite_sram_slave #(.WAIT_STATES(2)) u_dut2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel2), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(hrdata2), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HREADY(hreadyout2), .HREADYOUT(hreadyout2), .HRESP(hresp2)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic add_wr(input string tag, input logic [31:0] a, input logic [2:0] s,
                        input logic [31:0] d, input bit err, input int waits);
    req_t r;
    r.tag = tag; r.wr = 1'b1; r.addr = a; r.size = s; r.wdata = d;
    r.err = err; r.chk = 1'b0; r.rdata = '0; r.waits = waits;
    q_req.push_back(r);
  endtask

  task automatic add_rd(input string tag, input logic [31:0] a, input logic [2:0] s,
                        input logic [31:0] exp, input bit err, input int waits);
    req_t r;
    r.tag = tag; r.wr = 1'b0; r.addr = a; r.size = s; r.wdata = '0;
    r.err = err; r.chk = !err; r.rdata = exp; r.waits = waits;
    q_req.push_back(r);
  endtask

  task automatic bus_idle();
    hsel0 = 1'b0; hsel2 = 1'b0; htrans = 2'b00; haddr = '0;
    hwrite = 1'b0; hsize = 3'd0; hwdata = '0;
  endtask

  // Entered and left just after a rising edge with the bus idle.
  task automatic run_seq(input bit use2);
    req_t        ap;
    exp_t        e;
    bit          ap_v = 1'b0, dp_v = 1'b0;
    logic [31:0] dp_wdata = '0;
    int          n_low = 0, low_resp1 = 0, guard = 0;
    logic        rdy, rsp;
    logic [31:0] rd;
    while (1) begin
      if (!ap_v && q_req.size() > 0) begin
        ap = q_req.pop_front();
        ap_v = 1'b1;
        e.tag = ap.tag; e.err = ap.err; e.chk = ap.chk; e.rdata = ap.rdata; e.waits = ap.waits;
        q_exp.push_back(e);
      end
      hsel0  = ap_v && !use2;
      hsel2  = ap_v && use2;
      htrans = ap_v ? 2'b10 : 2'b00;
      haddr  = ap_v ? ap.addr : '0;
      hwrite = ap_v && ap.wr;
      hsize  = ap_v ? ap.size : 3'd0;
      hwdata = dp_wdata;
      @(negedge HCLK);
      rdy = use2 ? hreadyout2 : hreadyout0;
      rsp = use2 ? hresp2 : hresp0;
      rd  = use2 ? hrdata2 : hrdata0;
      if (!dp_v) begin
        check("idle ready", rdy, 1'b1);
        check("idle resp", rsp, 1'b0);
        check("idle rdata", rd, '0);
      end else if (!rdy) begin
        n_low++;
        if (rsp) low_resp1++;
        check({q_exp[0].tag, " rdata_stall"}, rd, '0);
      end else begin
        e = q_exp.pop_front();
        check({e.tag, " stall"}, 32'(n_low), e.err ? 32'd1 : 32'(e.waits));
        check({e.tag, " resp_low"}, 32'(low_resp1), e.err ? 32'd1 : 32'd0);
        check({e.tag, " resp"}, rsp, e.err);
        if (e.chk) check({e.tag, " rdata"}, rd, e.rdata);
        if (e.err) check({e.tag, " rdata_err"}, rd, '0);
        n_low = 0;
        low_resp1 = 0;
      end
      @(posedge HCLK);
      #1;
      if (rdy) begin
        dp_v     = ap_v;
        dp_wdata = ap_v ? ap.wdata : '0;
        ap_v     = 1'b0;
      end
      if (!ap_v && !dp_v && q_req.size() == 0) break;
      guard++;
      if (guard > 500) begin
        n_checks++;
        n_fail++;
        $error("FAIL run_seq timeout observed=%0d cycles required<=500", guard);
        q_req.delete();
        q_exp.delete();
        break;
      end
    end
    bus_idle();
  endtask

  initial begin
    bus_idle();
    hburst  = 3'd0;
    hprot   = 4'd0;
    HRESETn = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge HCLK);
      check($sformatf("reset%0d ready0", i), hreadyout0, 1'b1);
      check($sformatf("reset%0d resp0", i), hresp0, 1'b0);
      check($sformatf("reset%0d rdata0", i), hrdata0, '0);
      check($sformatf("reset%0d ready2", i), hreadyout2, 1'b1);
      check($sformatf("reset%0d resp2", i), hresp2, 1'b0);
      check($sformatf("reset%0d rdata2", i), hrdata2, '0);
    end
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    @(negedge HCLK);
    check("post_reset ready0", hreadyout0, 1'b1);
    check("post_reset resp2", hresp2, 1'b0);
    check("post_reset rdata2", hrdata2, '0);
    @(posedge HCLK);
    #1;

    // Zero-wait write then back-to-back read of the same word.
    add_wr("w0_10", 32'h10, 3'd2, 32'hDEADBEEF, 1'b0, 0);
    add_rd("r0_10", 32'h10, 3'd2, 32'hDEADBEEF, 1'b0, 0);
    run_seq(1'b0);

    // Byte and halfword lanes; unselected lanes carry junk that must not land.
    add_wr("wb_20", 32'h20, 3'd0, 32'hEEEEEE11, 1'b0, 0);
    add_wr("wb_21", 32'h21, 3'd0, 32'hEEEE22EE, 1'b0, 0);
    add_wr("wh_22", 32'h22, 3'd1, 32'h4433EEEE, 1'b0, 0);
    add_rd("r_20", 32'h20, 3'd2, 32'h44332211, 1'b0, 0);
    run_seq(1'b0);

    // Illegal transfers back-to-back, then the touched words read back unchanged.
    add_wr("w0_00", 32'h00, 3'd2, 32'h0BADF00D, 1'b0, 0);
    add_wr("err_word_02", 32'h02, 3'd2, 32'hFFFFFFFF, 1'b1, 0);
    add_wr("err_size3", 32'h00, 3'd3, 32'hFFFFFFFF, 1'b1, 0);
    add_wr("err_oob", 32'h400, 3'd2, 32'hFFFFFFFF, 1'b1, 0);
    add_wr("err_half_11", 32'h11, 3'd1, 32'hFFFFFFFF, 1'b1, 0);
    add_rd("err_rd_oob", 32'h404, 3'd2, '0, 1'b1, 0);
    add_rd("r_00_after_err", 32'h00, 3'd2, 32'h0BADF00D, 1'b0, 0);
    add_rd("r_10_after_err", 32'h10, 3'd2, 32'hDEADBEEF, 1'b0, 0);
    run_seq(1'b0);

    // Two wait states per OKAY transfer, back-to-back NONSEQ.
    add_wr("w2_10", 32'h10, 3'd2, 32'hCAFEF00D, 1'b0, 2);
    add_wr("w2_14", 32'h14, 3'd2, 32'h12345678, 1'b0, 2);
    add_wr("w2_18", 32'h18, 3'd2, 32'h9ABCDEF0, 1'b0, 2);
    add_rd("r2_10", 32'h10, 3'd2, 32'hCAFEF00D, 1'b0, 2);
    add_rd("r2_14", 32'h14, 3'd2, 32'h12345678, 1'b0, 2);
    add_wr("err2_02", 32'h02, 3'd2, 32'hFFFFFFFF, 1'b1, 2);
    add_rd("r2_18", 32'h18, 3'd2, 32'h9ABCDEF0, 1'b0, 2);
    add_wr("w2_30", 32'h30, 3'd2, 32'hA5A5A5A5, 1'b0, 2);
    run_seq(1'b1);

    // Reset lands while a write to 0x30 is still stalled.
    hsel2 = 1'b1; htrans = 2'b10; haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2;
    @(posedge HCLK);
    #1;
    bus_idle();
    hwdata = 32'h5A5A1234;
    @(negedge HCLK);
    check("rst_mid entered_wait", hreadyout2, 1'b0);
    HRESETn = 1'b0;
    @(posedge HCLK);
    #1;
    @(negedge HCLK);
    check("rst_mid ready", hreadyout2, 1'b1);
    check("rst_mid resp", hresp2, 1'b0);
    check("rst_mid rdata", hrdata2, '0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    hwdata  = '0;
    @(posedge HCLK);
    #1;
    add_rd("r2_30_after_rst", 32'h30, 3'd2, 32'hA5A5A5A5, 1'b0, 2);
    run_seq(1'b1);

    // IDLE and BUSY with HSEL high: zero-wait OKAY and no write.
    for (int k = 0; k < 2; k++) begin
      hsel0 = 1'b1; htrans = 2'(k); haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2;
      hwdata = 32'hFFFFFFFF;
      @(posedge HCLK);
      #1;
      @(negedge HCLK);
      check($sformatf("htrans%0d ready", k), hreadyout0, 1'b1);
      check($sformatf("htrans%0d resp", k), hresp0, 1'b0);
      check($sformatf("htrans%0d rdata", k), hrdata0, '0);
      @(posedge HCLK);
      #1;
    end
    bus_idle();
    add_rd("r0_10_after_idle", 32'h10, 3'd2, 32'hDEADBEEF, 1'b0, 0);
    add_rd("r0_20_after_idle", 32'h20, 3'd2, 32'h44332211, 1'b0, 0);
    run_seq(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb3lite_sram_slave.md
Name: ahb3lite_sram_slave

Overview:
AHB3-Lite subordinate (responder) backed by a word-organised on-chip memory, with a configurable number of wait states and two-cycle ERROR responses. It is the target end of the AHB3-Lite master tasks in the simulation environment and lets the bench perform real write/read round-trips. It sits behind the decoder (HSEL) and receives the system HREADY.

Parameters:
HADDR_SIZE, 32, address bus width
HDATA_SIZE, 32, data bus width (32 only; byte lanes = HDATA_SIZE/8)
MEM_DEPTH, 256, number of HDATA_SIZE-wide words
WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY transfer (0..15)

Ports:
HCLK  in  1  clock, rising edge
HRESETn  in  1  reset, synchronous, active-low
HSEL  in  1  slave select
HADDR  in  HADDR_SIZE  byte address
HWDATA  in  HDATA_SIZE  write data, valid in data phase
HRDATA  out  HDATA_SIZE  read data
HWRITE  in  1  1=write, 0=read
HSIZE  in  3  transfer size (0=byte, 1=half, 2=word)
HBURST  in  3  burst type (ignored; each beat handled independently)
HPROT  in  4  protection (ignored)
HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
HREADY  in  1  system ready (previous transfer complete)
HREADYOUT  out  1  slave ready
HRESP  out  1  0=OKAY, 1=ERROR

Behaviour:
- One clock; reset is synchronous and active-low (HRESETn sampled on rising HCLK).
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0, captured address-phase regs=0. Memory contents not cleared.
- Address phase accepted at a rising edge when HSEL & HREADY & HTRANS[1]. Captured: word index = HADDR[log2(MEM_DEPTH)+1:2], HADDR[1:0], HSIZE, HWRITE.
- IDLE/BUSY with HSEL & HREADY, or HSEL=0: no transfer, next cycle HREADYOUT=1, HRESP=0.
- Error check at capture: HSIZE>2; misaligned (half with HADDR[0]=1, word with HADDR[1:0]!=0); HADDR >= 4*MEM_DEPTH.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE/DATA/ERR2 + accepted legal transfer -> WAIT if WAIT_STATES>0 (counter loaded WAIT_STATES-1), else DATA.
  - accepted illegal transfer -> ERR1.
  - no accepted transfer -> IDLE.
  - WAIT: HREADYOUT=0, HRESP=0; decrement; at 0 -> DATA.
  - DATA: HREADYOUT=1, HRESP=0; transfer completes this cycle.
  - ERR1: HREADYOUT=0, HRESP=1; always -> ERR2 (not cancellable).
  - ERR2: HREADYOUT=1, HRESP=1; a new address phase may be accepted this cycle.
- Write: memory updated at the edge ending DATA. Only byte lanes selected by HSIZE and HADDR[1:0] written (byte: lane addr[1:0]; half: lanes addr[1]*2+{0,1}; word: all). Errored writes modify nothing.
- Read: in DATA, HRDATA = full word mem[index] (combinational from captured index); master selects lanes. HRDATA=0 in all other states.
- Write followed by read of the same address back-to-back: the read returns the newly written data (write commits at the edge where the read address is captured).
- Reset asserted mid-transfer (WAIT/ERR1): pending write discarded; outputs return to reset values next cycle.

Test Plan:
- Reset held low 5 cycles -> HREADYOUT=1, HRESP=0, HRDATA=0 throughout and after release.
- WAIT_STATES=0: word write 0xDEADBEEF @0x10, then read @0x10 -> HRDATA=0xDEADBEEF in read data phase, HREADYOUT=1, HRESP=0, no stall.
- Byte writes 0x11@0x20, 0x22@0x21, half 0x4433@0x22, then word read @0x20 -> 0x44332211.
- WAIT_STATES=2: word read @0x10 -> HREADYOUT low exactly 2 cycles, then high with data; back-to-back NONSEQ writes each stall 2 cycles.
- Illegal: word @0x02, HSIZE=3 @0x0, and @4*MEM_DEPTH -> HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1; subsequent read of affected words shows prior contents unchanged.
- Reset asserted during WAIT of a write to @0x30 (prior 0xA5A5A5A5) -> read after reset returns 0xA5A5A5A5; IDLE/BUSY with HSEL=1 -> zero-wait OKAY, no memory change.
